// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer (master) and the VGA renderer/motion datapath (slave).
interface pong_game_ctrl_if;
  // Every signal is single-direction with no valid/ready. vs and btn_start are raw asynchronous
  // levels. hit and miss are 1-clk pulses from the motion block. All outputs are registered
  // levels, except ball_reload, which is a registered 1-clk pulse.
  logic       vs;
  logic       btn_start;
  logic       hit;
  logic       miss;
  logic [1:0] state;
  logic       run_en;
  logic       ball_reload;
  logic [3:0] speed;
  logic [3:0] score_lo;
  logic [3:0] score_hi;
  logic       lose;
  logic [2:0] lives_left;

  modport master (
    input  vs, btn_start, hit, miss,
    output state, run_en, ball_reload, speed, score_lo, score_hi, lose, lives_left
  );

  modport slave (
    output vs, btn_start, hit, miss,
    input  state, run_en, ball_reload, speed, score_lo, score_hi, lose, lives_left
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE/SERVE/PLAY/OVER flow, BCD score, speed levels and frame-timed phases.
// Optional multi-ball play is enabled by defining PONG_LIVES_EN.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 8,
  parameter int HITS_PER_LVL = 5,
  parameter int LIVES        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pong_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic       btn_meta_q, btn_sync_q, btn_prev_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] speed_q, speed_d;
  logic [3:0] score_lo_q, score_lo_d;
  logic [3:0] score_hi_q, score_hi_d;
  logic       run_en_q, run_en_d;
  logic       lose_q, lose_d;
  logic       ball_reload_q, ball_reload_d;
  logic       frame_tick, start_pulse, new_game, hit_play, miss_play, last_ball;

  // vs idles high, so its synchroniser resets high to avoid a false frame tick out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      vs_meta_q  <= bus.vs;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
      btn_meta_q <= bus.btn_start;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign frame_tick  = vs_prev_q & ~vs_sync_q;
  assign start_pulse = btn_sync_q & ~btn_prev_q;
  assign new_game    = (state_q == ST_IDLE) & start_pulse;
  assign miss_play   = (state_q == ST_PLAY) & bus.miss;
  assign hit_play    = (state_q == ST_PLAY) & bus.hit & ~bus.miss;

`ifdef PONG_LIVES_EN
  logic [2:0] lives_q, lives_d;

  assign last_ball = (lives_q <= 3'd1);

  always_comb begin
    lives_d = lives_q;
    if (new_game) begin
      lives_d = 3'(LIVES);
    end else if (miss_play) begin
      lives_d = last_ball ? 3'd0 : lives_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lives_q <= 3'(LIVES);
    else        lives_q <= lives_d;
  end

  assign bus.lives_left = lives_q;
`else
  assign last_ball      = 1'b1;
  assign bus.lives_left = 3'(LIVES);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_pulse) state_d = ST_SERVE;
      ST_SERVE: if (frame_tick && frame_cnt_q == 8'(SERVE_FRAMES - 1)) state_d = ST_PLAY;
      ST_PLAY:  if (miss_play) state_d = last_ball ? ST_OVER : ST_SERVE;
      ST_OVER:  if (frame_tick && frame_cnt_q == 8'(OVER_FRAMES - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so they line up with state_q after the edge
  always_comb begin
    run_en_d      = (state_d == ST_PLAY);
    lose_d        = (state_d == ST_OVER);
    ball_reload_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
  end

  // Datapath next values: frame timer, score, hit level and speed
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    score_lo_d  = score_lo_q;
    score_hi_d  = score_hi_q;
    hit_cnt_d   = hit_cnt_q;
    speed_d     = speed_q;

    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frame_tick && (state_q == ST_SERVE || state_q == ST_OVER)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (new_game) begin
      score_lo_d = 4'd0;
      score_hi_d = 4'd0;
      hit_cnt_d  = 4'd0;
      speed_d    = 4'(SPEED_INIT);
    end else if (hit_play) begin
      if (!(score_hi_q == 4'd9 && score_lo_q == 4'd9)) begin
        if (score_lo_q == 4'd9) begin
          score_lo_d = 4'd0;
          score_hi_d = score_hi_q + 4'd1;
        end else begin
          score_lo_d = score_lo_q + 4'd1;
        end
      end
      if (hit_cnt_q == 4'(HITS_PER_LVL - 1)) begin
        hit_cnt_d = 4'd0;
        if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
      end else begin
        hit_cnt_d = hit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= 8'd0;
      hit_cnt_q     <= 4'd0;
      speed_q       <= 4'(SPEED_INIT);
      score_lo_q    <= 4'd0;
      score_hi_q    <= 4'd0;
      run_en_q      <= 1'b0;
      lose_q        <= 1'b0;
      ball_reload_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      speed_q       <= speed_d;
      score_lo_q    <= score_lo_d;
      score_hi_q    <= score_hi_d;
      run_en_q      <= run_en_d;
      lose_q        <= lose_d;
      ball_reload_q <= ball_reload_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.run_en      = run_en_q;
  assign bus.ball_reload = ball_reload_q;
  assign bus.speed       = speed_q;
  assign bus.score_lo    = score_lo_q;
  assign bus.score_hi    = score_hi_q;
  assign bus.lose        = lose_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: randomised hit timing against a score/speed/lives model.
module tb_pong_game_ctrl;
  localparam int SERVE_FRAMES = 60;
  localparam int OVER_FRAMES  = 180;
  localparam int SPEED_INIT   = 2;
  localparam int SPEED_MAX    = 8;
  localparam int HITS_PER_LVL = 5;
  localparam int LIVES        = 3;
  localparam logic [1:0] S_IDLE = 2'b00, S_SERVE = 2'b01, S_PLAY = 2'b10, S_OVER = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Behavioural model: plain integers for score, total hits in this game and balls left.
  int         m_score = 0;
  int         m_hits = 0;
  int         m_lives = LIVES;
  logic [1:0] m_state = S_IDLE;
  logic [7:0] exp_q[$];

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .SERVE_FRAMES(SERVE_FRAMES), .OVER_FRAMES(OVER_FRAMES), .SPEED_INIT(SPEED_INIT),
    .SPEED_MAX(SPEED_MAX), .HITS_PER_LVL(HITS_PER_LVL), .LIVES(LIVES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_speed();
    int s = SPEED_INIT + m_hits / HITS_PER_LVL;
    if (s > SPEED_MAX) s = SPEED_MAX;
    return 4'(s);
  endfunction

  function automatic logic [7:0] m_bcd();
    logic [7:0] b;
    b[7:4] = 4'(m_score / 10);
    b[3:0] = 4'(m_score % 10);
    return b;
  endfunction

  task automatic frame();
    bus.vs = 1'b0;
    repeat (4) @(posedge clk);
    bus.vs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (bus.state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_IDLE); end
    total++; if (bus.run_en !== 1'b0) begin bad++; $display("FAIL reset_run_en: got %0b want 0", bus.run_en); end
    total++; if (bus.ball_reload !== 1'b0) begin bad++; $display("FAIL reset_reload: got %0b want 0", bus.ball_reload); end
    total++; if (bus.speed !== 4'(SPEED_INIT)) begin bad++; $display("FAIL reset_speed: got %0d want %0d", bus.speed, SPEED_INIT); end
    total++; if ({bus.score_hi, bus.score_lo} !== 8'h00) begin bad++; $display("FAIL reset_score: got %h want 00", {bus.score_hi, bus.score_lo}); end
    total++; if (bus.lose !== 1'b0) begin bad++; $display("FAIL reset_lose: got %0b want 0", bus.lose); end
    total++; if (bus.lives_left !== 3'(LIVES)) begin bad++; $display("FAIL reset_lives: got %0d want %0d", bus.lives_left, LIVES); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_state = S_IDLE; m_score = 0; m_hits = 0; m_lives = LIVES;
    idle_clks(3);
    total++; if (bus.state !== S_IDLE) begin bad++; $display("FAIL reset_hold_idle: got %0d want %0d", bus.state, S_IDLE); end
  endtask

  // One hit and/or miss pulse, 1 clk wide; every output compared with the model after the edge.
  task automatic do_pulse(input bit h, input bit m);
    logic exp_reload = 1'b0;
    bus.hit = h; bus.miss = m;
    @(posedge clk); #1;
    bus.hit = 1'b0; bus.miss = 1'b0;
    if (m_state == S_PLAY) begin
      if (m) begin
`ifdef PONG_LIVES_EN
        m_lives--;
        if (m_lives > 0) begin m_state = S_SERVE; exp_reload = 1'b1; end
        else m_state = S_OVER;
`else
        m_state = S_OVER;
`endif
      end else if (h) begin
        m_hits++;
        if (m_score < 99) m_score++;
      end
    end
    exp_q.push_back(m_bcd());
    total++; if ({bus.score_hi, bus.score_lo} !== exp_q[0]) begin bad++; $display("FAIL pulse_score: got %h want %h", {bus.score_hi, bus.score_lo}, exp_q[0]); end
    void'(exp_q.pop_front());
    total++; if (bus.state !== m_state) begin bad++; $display("FAIL pulse_state: got %0d want %0d", bus.state, m_state); end
    total++; if (bus.speed !== m_speed()) begin bad++; $display("FAIL pulse_speed: got %0d want %0d", bus.speed, m_speed()); end
    total++; if (bus.ball_reload !== exp_reload) begin bad++; $display("FAIL pulse_reload: got %0b want %0b", bus.ball_reload, exp_reload); end
    total++; if (bus.lives_left !== 3'(m_lives)) begin bad++; $display("FAIL pulse_lives: got %0d want %0d", bus.lives_left, m_lives); end
    total++; if (bus.run_en !== (m_state == S_PLAY)) begin bad++; $display("FAIL pulse_run_en: got %0b want %0b", bus.run_en, m_state == S_PLAY); end
  endtask

  task automatic test_start();
    int pulses = 0;
    bus.btn_start = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (bus.ball_reload === 1'b1) pulses++;
    end
    bus.btn_start = 1'b0;
    m_state = S_SERVE; m_score = 0; m_hits = 0; m_lives = LIVES;
    total++; if (pulses != 1) begin bad++; $display("FAIL start_reload_count: got %0d want 1", pulses); end
    total++; if (bus.state !== S_SERVE) begin bad++; $display("FAIL start_state: got %0d want %0d", bus.state, S_SERVE); end
    total++; if ({bus.score_hi, bus.score_lo} !== 8'h00) begin bad++; $display("FAIL start_score: got %h want 00", {bus.score_hi, bus.score_lo}); end
    total++; if (bus.speed !== 4'(SPEED_INIT)) begin bad++; $display("FAIL start_speed: got %0d want %0d", bus.speed, SPEED_INIT); end
    idle_clks(3);
  endtask

  task automatic test_serve();
    do_pulse(1'b1, 1'b0);
    repeat (SERVE_FRAMES - 1) frame();
    total++; if (bus.state !== S_SERVE) begin bad++; $display("FAIL serve_hold: got %0d want %0d", bus.state, S_SERVE); end
    total++; if (bus.run_en !== 1'b0) begin bad++; $display("FAIL serve_run_en: got %0b want 0", bus.run_en); end
    frame();
    m_state = S_PLAY;
    total++; if (bus.state !== S_PLAY) begin bad++; $display("FAIL serve_to_play: got %0d want %0d", bus.state, S_PLAY); end
    total++; if (bus.run_en !== 1'b1) begin bad++; $display("FAIL play_run_en: got %0b want 1", bus.run_en); end
  endtask

  task automatic test_hits(input int n);
    for (int i = 0; i < n; i++) begin
      idle_clks($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) frame();
      do_pulse(1'b1, 1'b0);
    end
  endtask

  task automatic test_miss_to_over();
    for (int guard = 0; guard < 8 && m_state != S_OVER; guard++) begin
      if (m_state == S_SERVE) test_serve();
      do_pulse(1'b0, 1'b1);
    end
    total++; if (bus.lose !== 1'b1) begin bad++; $display("FAIL over_lose: got %0b want 1", bus.lose); end
  endtask

  task automatic test_over();
    logic [7:0] held = m_bcd();
    repeat (99) frame();
    bus.btn_start = 1'b1;
    frame();
    bus.btn_start = 1'b0;
    repeat (OVER_FRAMES - 101) frame();
    total++; if (bus.state !== S_OVER) begin bad++; $display("FAIL over_hold: got %0d want %0d", bus.state, S_OVER); end
    total++; if (bus.lose !== 1'b1) begin bad++; $display("FAIL over_hold_lose: got %0b want 1", bus.lose); end
    frame();
    m_state = S_IDLE;
    total++; if (bus.state !== S_IDLE) begin bad++; $display("FAIL over_to_idle: got %0d want %0d", bus.state, S_IDLE); end
    total++; if (bus.lose !== 1'b0) begin bad++; $display("FAIL idle_lose: got %0b want 0", bus.lose); end
    total++; if ({bus.score_hi, bus.score_lo} !== held) begin bad++; $display("FAIL idle_score_held: got %h want %h", {bus.score_hi, bus.score_lo}, held); end
    total++; if (bus.speed !== m_speed()) begin bad++; $display("FAIL idle_speed_held: got %0d want %0d", bus.speed, m_speed()); end
    do_pulse(1'b1, 1'b1);
  endtask

  initial begin
    bus.vs = 1'b1; bus.btn_start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
    idle_clks(2);
    test_reset();
    // Game 1: reach 37 then reset in the middle of play
    test_start();
    test_serve();
    test_hits(37);
    test_reset();
    // Game 2: BCD carry 09->10, then hit+miss together at 14
    test_start();
    test_serve();
    test_hits(14);
    do_pulse(1'b1, 1'b1);
    test_miss_to_over();
    test_over();
    // Game 3: saturate speed and score
    test_start();
    test_serve();
    test_hits(100);
    total++; if ({bus.score_hi, bus.score_lo} !== 8'h99) begin bad++; $display("FAIL sat_score: got %h want 99", {bus.score_hi, bus.score_lo}); end
    total++; if (bus.speed !== 4'(SPEED_MAX)) begin bad++; $display("FAIL sat_speed: got %0d want %0d", bus.speed, SPEED_MAX); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
